// File: rtl/spi_key_loader.sv
// spi_key_loader: SPI mode-0 slave that shifts in a 32*NK-bit cipher key and
// presents it on keyout as one parallel word. keyout is double-buffered, so
// it changes once and atomically when a frame completes. Partial frames are
// discarded.
//
// Optional feature macro: SPI_KEY_READBACK_EN. When it is defined, miso
// echoes the current keyout while a new key is shifted in. When it is
// undefined, miso is tied low and no readback logic is built.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active low
//   sclk       SPI clock, asynchronous to clk, f_sclk <= f_clk/8
//   cs_n       SPI chip select, active low, asynchronous
//   mosi       SPI data in, first bit lands in keyout[0]
//   miso       SPI data out (readback of the previous key, or 0)
//   keyout     last complete key, bit 0 = first bit received
//   key_valid  1-clk pulse when keyout is updated
//   busy       high while a frame is being shifted in
//   frame_err  1-clk pulse on aborted frame or overrun
module spi_key_loader #(
  parameter int unsigned NK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [0:32*NK-1]  keyout,
  output logic              key_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned KeyW = 32 * NK;
  localparam int unsigned CntW = $clog2(KeyW) + 1;

  typedef enum logic [2:0] {StIdle, StShift, StDone, StHold, StErr} state_e;

  state_e state_q, state_d;

  // Two-flop synchronisers plus one history flop for edge detection.
  logic sclk_s1, sclk_s2, sclk_h;
  logic cs_s1, cs_s2, cs_h;
  logic mosi_s1, mosi_s2;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [0:KeyW-1] sr_q, sr_d;
  logic [0:KeyW-1] key_q;
  logic            key_valid_q, frame_err_q, ovr_q;

  logic sclk_rise, cs_rise, cs_fall, last_bit;
  logic shift_en, cnt_clr, load_key, ovr_set, frame_err_d;

  assign sclk_rise = sclk_s2 & ~sclk_h;
  assign cs_rise   = cs_s2 & ~cs_h;
  assign cs_fall   = ~cs_s2 & cs_h;
  // Final bit arriving with a cs_n rise in the same clk still completes.
  assign last_bit  = sclk_rise && (cnt_q == CntW'(KeyW - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cs_fall) state_d = StShift;
      StShift: begin
        if (last_bit) begin
          state_d = StDone;
        end else if (cs_rise) begin
          state_d = StErr;
        end
      end
      StDone:  state_d = StHold;
      StHold:  if (cs_rise) state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath control
  always_comb begin
    cnt_clr     = (state_q == StIdle) && cs_fall;
    // cs_n rise outranks a non-final sclk rise.
    shift_en    = (state_q == StShift) && sclk_rise && (last_bit || !cs_rise);
    load_key    = (state_q == StDone);
    // Only the first extra sclk rise in HOLD is reported.
    ovr_set     = (state_q == StHold) && sclk_rise && !cs_rise && !ovr_q;
    frame_err_d = (state_q == StErr) || ovr_set;
    sr_d        = shift_en ? {sr_q[1:KeyW-1], mosi_s2} : sr_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (shift_en) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_s1     <= 1'b0;
      sclk_s2     <= 1'b0;
      sclk_h      <= 1'b0;
      cs_s1       <= 1'b1;
      cs_s2       <= 1'b1;
      cs_h        <= 1'b1;
      mosi_s1     <= 1'b0;
      mosi_s2     <= 1'b0;
      cnt_q       <= '0;
      sr_q        <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      sclk_s1     <= sclk;
      sclk_s2     <= sclk_s1;
      sclk_h      <= sclk_s2;
      cs_s1       <= cs_n;
      cs_s2       <= cs_s1;
      cs_h        <= cs_s2;
      mosi_s1     <= mosi;
      mosi_s2     <= mosi_s1;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      key_valid_q <= load_key;
      frame_err_q <= frame_err_d;
      if (load_key) begin
        key_q <= sr_q;
        ovr_q <= 1'b0;
      end else if (ovr_set) begin
        ovr_q <= 1'b1;
      end
    end
  end

`ifdef SPI_KEY_READBACK_EN
  localparam int unsigned IdxW = $clog2(KeyW);
  logic            miso_q;
  logic [IdxW-1:0] rb_idx;

  // Present the bit the host samples on its next sclk rise.
  assign rb_idx = cnt_d[IdxW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miso_q <= 1'b0;
    end else begin
      miso_q <= (state_d == StShift) ? key_q[rb_idx] : 1'b0;
    end
  end

  assign miso = miso_q;
`else
  assign miso = 1'b0;
`endif

  assign keyout    = key_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == StShift);

endmodule

// File: tb/tb_spi_key_loader.sv
// Directed bench for spi_key_loader: an NK=4 and an NK=8 instance share sclk
// and mosi but have separate chip selects.
module tb_spi_key_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic cs_n4 = 1'b1;
  logic cs_n8 = 1'b1;

  logic           miso4, key_valid4, busy4, frame_err4;
  logic [0:127]   keyout4;
  logic           miso8, key_valid8, busy8, frame_err8;
  logic [0:255]   keyout8;

  int errors = 0;
  int checks = 0;

  // Pulse counters, written only by the monitor.
  int kv4 = 0, fe4 = 0, kv8 = 0, fe8 = 0, both = 0;
  bit miso4_seen = 1'b0, miso8_seen = 1'b0;

  // miso samples taken at each sclk rise of an NK=4 frame.
  bit mand, mor;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  spi_key_loader #(.NK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n4), .mosi(mosi),
    .miso(miso4), .keyout(keyout4), .key_valid(key_valid4), .busy(busy4),
    .frame_err(frame_err4)
  );

  spi_key_loader #(.NK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n8), .mosi(mosi),
    .miso(miso8), .keyout(keyout8), .key_valid(key_valid8), .busy(busy8),
    .frame_err(frame_err8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (key_valid4) kv4++;
    if (frame_err4) fe4++;
    if (key_valid8) kv8++;
    if (frame_err8) fe8++;
    if ((key_valid4 && frame_err4) || (key_valid8 && frame_err8)) both++;
    if (miso8) miso8_seen = 1'b1;
`ifndef SPI_KEY_READBACK_EN
    if (miso4) miso4_seen = 1'b1;
`endif
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends nbits of data MSB-first (data is left-aligned in 256 bits).
  task automatic frame(input logic [255:0] data, input int nbits, input bit sel8,
                       input bit raise);
    if (sel8) cs_n8 = 1'b0;
    else cs_n4 = 1'b0;
    #40;
    for (int i = 0; i < nbits; i++) begin
      mosi = data[255-i];
      #40;
      if (!sel8) begin
        mand = mand & miso4;
        mor  = mor | miso4;
      end
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
    #40;
    if (raise) begin
      cs_n4 = 1'b1;
      cs_n8 = 1'b1;
      #80;
    end
  endtask

  int kv_s, fe_s;

  initial begin
    // Reset state
    #30;
    check("rst_keyout4", 256'(keyout4), 256'h0);
    check("rst_keyout8", {keyout8}, 256'h0);
    check("rst_outs4", 256'({key_valid4, busy4, frame_err4, miso4}), 256'h0);
    check("rst_outs8", 256'({key_valid8, busy8, frame_err8, miso8}), 256'h0);
    rst_n = 1'b1;
    #20;

    // Full load
    kv_s = kv4; fe_s = fe4;
    frame({K1, 128'h0}, 128, 1'b0, 1'b1);
    check("load_key", 256'(keyout4), 256'(K1));
    check("load_kv", 256'(kv4 - kv_s), 256'd1);
    check("load_fe", 256'(fe4 - fe_s), 256'd0);
    check("load_busy", 256'(busy4), 256'd0);

    // Abort after 100 bits
    kv_s = kv4; fe_s = fe4;
    frame({K2, 128'h0}, 100, 1'b0, 1'b1);
    check("abort_fe", 256'(fe4 - fe_s), 256'd1);
    check("abort_kv", 256'(kv4 - kv_s), 256'd0);
    check("abort_key", 256'(keyout4), 256'(K1));

    // Overrun: 130 bits
    kv_s = kv4; fe_s = fe4;
    frame({K2, 2'b11, 126'h0}, 130, 1'b0, 1'b1);
    check("ovr_kv", 256'(kv4 - kv_s), 256'd1);
    check("ovr_fe", 256'(fe4 - fe_s), 256'd1);
    check("ovr_key", 256'(keyout4), 256'(K2));

    // Reset mid-frame at bit 64
    frame({K1, 128'h0}, 64, 1'b0, 1'b0);
    check("mid_busy", 256'(busy4), 256'd1);
    rst_n = 1'b0;
    #20;
    check("mid_rst_key", 256'(keyout4), 256'h0);
    check("mid_rst_outs", 256'({key_valid4, busy4, frame_err4, miso4}), 256'h0);
    cs_n4 = 1'b1;
    #20;
    rst_n = 1'b1;
    #80;
    kv_s = kv4;
    frame({K1, 128'h0}, 128, 1'b0, 1'b1);
    check("after_rst_key", 256'(keyout4), 256'(K1));
    check("after_rst_kv", 256'(kv4 - kv_s), 256'd1);

    // NK=8 load with latency check on the last bit
    kv_s = kv8; fe_s = fe8;
    frame(K256, 255, 1'b1, 1'b0);
    mosi = K256[0];
    #40;
    sclk = 1'b1;
    #30;
    check("nk8_kv_early", 256'(key_valid8), 256'd0);
    #10;
    check("nk8_kv_on", 256'(key_valid8), 256'd1);
    #10;
    check("nk8_kv_off", 256'(key_valid8), 256'd0);
    sclk = 1'b0;
    #40;
    cs_n8 = 1'b1;
    #80;
    check("nk8_key", {keyout8}, K256);
    check("nk8_kv_cnt", 256'(kv8 - kv_s), 256'd1);
    check("nk8_fe_cnt", 256'(fe8 - fe_s), 256'd0);
    check("nk8_nk4_key", 256'(keyout4), 256'(K1));

    // Readback: zeros, then ones (echo zeros), then zeros (echo ones)
    frame(256'h0, 128, 1'b0, 1'b1);
    mand = 1'b1; mor = 1'b0;
    frame({128'hffffffffffffffffffffffffffffffff, 128'h0}, 128, 1'b0, 1'b1);
    check("rb_ones_key", 256'(keyout4), 256'(128'hffffffffffffffffffffffffffffffff));
    check("rb_echo_zero", 256'(mor), 256'd0);
    mand = 1'b1; mor = 1'b0;
    frame(256'h0, 128, 1'b0, 1'b1);
    check("rb_zero_key", 256'(keyout4), 256'h0);
`ifdef SPI_KEY_READBACK_EN
    check("rb_echo_ones", 256'(mand), 256'd1);
`else
    check("miso4_quiet", 256'(miso4_seen), 256'd0);
    check("miso4_echo_off", 256'(mor), 256'd0);
`endif
    check("miso8_quiet", 256'(miso8_seen), 256'd0);
    check("kv_fe_exclusive", 256'(both), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
